// File: rtl/generic_mem.sv
// Byte-cell-addressable synchronous RAM with a registered single-cell port
// and simulation-only multi-cell little-endian load/read tasks.
module generic_mem #(
  parameter int unsigned log2_number_of_cells = 8,
  parameter int unsigned cell_size            = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [log2_number_of_cells-1:0] addr_bus,
  input  logic [cell_size-1:0]            data_bus_in,
  output logic [cell_size-1:0]            data_bus_out,
  input  logic                            we,
  input  logic                            re
);

  localparam int unsigned depth = 2 ** log2_number_of_cells;

  logic [cell_size-1:0] mem [depth];

  // mem is also written by loadn, so it cannot live in an always_ff block.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (we && !$isunknown(addr_bus) && !$isunknown(data_bus_in)) begin
      mem[addr_bus] <= data_bus_in;
    end
  end

  // Reads sample the pre-edge cell content, giving read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_bus_out <= '0;
    end else if (re && !$isunknown(addr_bus)) begin
      data_bus_out <= mem[addr_bus];
    end
  end

  task automatic loadn(input int n, input logic [4*cell_size-1:0] value,
                       input int unsigned addr);
    int unsigned                     cnt;
    logic [log2_number_of_cells-1:0] idx;
    if (rst !== 1'b0 || we !== 1'b1) return;
    cnt = (n <= 0) ? 32'd0 : (n > 4) ? 32'd4 : unsigned'(n);
    for (int unsigned i = 0; i < cnt; i++) begin
      idx      = log2_number_of_cells'(addr + i);
      mem[idx] = value[i*cell_size +: cell_size];
    end
  endtask

  task automatic readn(input int n, output logic [4*cell_size-1:0] out,
                       input int unsigned addr);
    int unsigned                     cnt;
    logic [log2_number_of_cells-1:0] idx;
    out = '0;
    if (rst !== 1'b0 || re !== 1'b1) return;
    cnt = (n <= 0) ? 32'd0 : (n > 4) ? 32'd4 : unsigned'(n);
    for (int unsigned i = 0; i < cnt; i++) begin
      idx                            = log2_number_of_cells'(addr + i);
      out[i*cell_size +: cell_size]  = mem[idx];
    end
  endtask

endmodule

// File: tb/tb_generic_mem.sv
// Bench for generic_mem: directed steps plus randomized traffic checked
// against an array-based reference of the memory contents.
module tb_generic_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr_bus;
  logic [7:0] data_bus_in;
  logic [7:0] data_bus_out;
  logic       we;
  logic       re;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [256];
  logic [7:0]  exp_dout;
  logic [31:0] rd;

  generic_mem #(.log2_number_of_cells(8), .cell_size(8)) dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus_in(data_bus_in),
    .data_bus_out(data_bus_out), .we(we), .re(re)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  task automatic model_load(input int n, input logic [31:0] v, input int a);
    int cnt;
    cnt = (n > 4) ? 4 : n;
    for (int i = 0; i < cnt; i++) model[(a + i) % 256] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] model_read(input int n, input int a);
    logic [31:0] r;
    int cnt;
    r = 32'h0;
    cnt = (n > 4) ? 4 : n;
    for (int i = 0; i < cnt; i++) r = r | ({24'h0, model[(a + i) % 256]} << (8 * i));
    return r;
  endfunction

  // Port edge: read sees old content, then the write lands.
  task automatic tick();
    @(posedge clk);
    if (re) exp_dout = model[addr_bus];
    if (we) model[addr_bus] = data_bus_in;
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; addr_bus = 8'h00; data_bus_in = 8'h00;
    model_clear();
    exp_dout = 8'h00;
    #3;
    check("reset_dout_during", {24'h0, data_bus_out}, 32'h0);
    #7 rst = 1'b0;

    // Port reads right after reset
    @(negedge clk); re = 1'b1; addr_bus = 8'h00; tick(); check("rst_rd_00", {24'h0, data_bus_out}, 32'h0);
    @(negedge clk); addr_bus = 8'h7F; tick(); check("rst_rd_7f", {24'h0, data_bus_out}, 32'h0);
    @(negedge clk); addr_bus = 8'hFF; tick(); check("rst_rd_ff", {24'h0, data_bus_out}, 32'h0);

    // Two-cell and four-cell loads
    @(negedge clk); re = 1'b0;
    we = 1'b1; dut.loadn(2, 32'h3812, 0); model_load(2, 32'h3812, 0); we = 1'b0;
    re = 1'b1; dut.readn(2, rd, 0); check("readn2", rd, 32'h00003812);
    check("readn2_model", rd, model_read(2, 0));
    we = 1'b1; dut.loadn(4, 32'h78945658, 4); model_load(4, 32'h78945658, 4); we = 1'b0;
    dut.readn(4, rd, 4); check("readn4", rd, 32'h78945658);
    dut.readn(2, rd, 0); check("readn4_keep01", rd, 32'h00003812);
    re = 1'b0;

    // Port latency and read-before-write
    @(negedge clk); we = 1'b1; addr_bus = 8'h10; data_bus_in = 8'hA5; tick();
    @(negedge clk); we = 1'b0; re = 1'b1; tick();
    check("port_rd_a5", {24'h0, data_bus_out}, 32'hA5);
    @(negedge clk); we = 1'b1; re = 1'b1; data_bus_in = 8'h5A; tick();
    check("rbw_old", {24'h0, data_bus_out}, 32'hA5);
    @(negedge clk); we = 1'b0; tick();
    check("rbw_new", {24'h0, data_bus_out}, 32'h5A);
    @(negedge clk); re = 1'b0; addr_bus = 8'h00; tick();
    check("re0_hold", {24'h0, data_bus_out}, 32'h5A);

    // Wrap-around
    we = 1'b1; dut.loadn(4, 32'hDDCCBBAA, 'hFE); model_load(4, 32'hDDCCBBAA, 'hFE); we = 1'b0;
    re = 1'b1; dut.readn(4, rd, 'hFE); check("wrap4", rd, 32'hDDCCBBAA);
    dut.readn(1, rd, 'h01); check("wrap_01", rd, 32'h000000DD);

    // Enable gating and argument rules
    we = 1'b0; dut.loadn(1, 32'h77, 2);
    dut.readn(1, rd, 2); check("loadn_we0", rd, {24'h0, model[2]});
    dut.readn(0, rd, 0); check("readn_n0", rd, 32'h0);
    dut.readn(6, rd, 'hFE); check("readn_clamp", rd, 32'hDDCCBBAA);
    we = 1'b1; dut.loadn(0, 32'hFFFFFFFF, 8); we = 1'b0;
    dut.readn(1, rd, 8); check("loadn_n0", rd, 32'h0);
    re = 1'b0; dut.readn(4, rd, 4); check("readn_re0", rd, 32'h0);

    // Randomized port and task traffic
    for (int k = 0; k < 400; k++) begin
      int n, a;
      logic [31:0] v;
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      addr_bus    = 8'($urandom_range(0, 31));
      data_bus_in = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        n = int'($urandom_range(0, 6)); a = int'($urandom_range(0, 255)); v = $urandom;
        dut.loadn(n, v, a);
        if (we) model_load(n, v, a);
      end
      if ($urandom_range(0, 3) == 0) begin
        n = int'($urandom_range(0, 6)); a = int'($urandom_range(0, 255));
        dut.readn(n, rd, a);
        check("rand_readn", rd, re ? model_read(n, a) : 32'h0);
      end
      tick();
      check("rand_dout", {24'h0, data_bus_out}, {24'h0, exp_dout});
    end

    // Mid-run asynchronous reset
    @(negedge clk); we = 1'b1; re = 1'b0; addr_bus = 8'h30; data_bus_in = 8'hC3; tick();
    @(negedge clk); we = 1'b0; re = 1'b1; tick();
    check("pre_rst_dout", {24'h0, data_bus_out}, 32'hC3);
    @(negedge clk); we = 1'b1; re = 1'b0; addr_bus = 8'h20; data_bus_in = 8'h99;
    #2 rst = 1'b1;
    #1 check("async_rst_dout", {24'h0, data_bus_out}, 32'h0);
    dut.loadn(4, 32'h11223344, 'h40);
    re = 1'b1; dut.readn(4, rd, 'h30); check("readn_in_rst", rd, 32'h0);
    @(posedge clk); #1 check("rst_hold_dout", {24'h0, data_bus_out}, 32'h0);
    @(negedge clk); rst = 1'b0; we = 1'b0; re = 1'b0;
    model_clear(); exp_dout = 8'h00;
    re = 1'b1;
    for (int a = 0; a < 256; a += 4) begin
      dut.readn(4, rd, a);
      check("post_rst_cells", rd, model_read(4, a));
    end
    addr_bus = 8'h20; tick();
    check("aborted_write", {24'h0, data_bus_out}, 32'h0);
    re = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
